// File: rtl/dna_pkg.sv
// Shared definitions for the DNA word orientation path: digit encodings,
// suffix classes and the reverse-word transform selectors.
package dna_pkg;

  localparam int DIGIT_W  = 2;
  localparam int SUFFIX_W = 2 * DIGIT_W;

  localparam logic [DIGIT_W-1:0] D1 = 2'b01;
  localparam logic [DIGIT_W-1:0] D2 = 2'b10;
  localparam logic [DIGIT_W-1:0] D3 = 2'b11;
  localparam logic [DIGIT_W-1:0] D4 = 2'b00;

  localparam int REV_MODE_REVERSE    = 0;
  localparam int REV_MODE_COMPLEMENT = 1;
  localparam int REV_MODE_REVCOMP    = 2;

  localparam int N_CLASSES = 4;

  typedef enum logic [1:0] {
    FWD_OK  = 2'd0,
    FWD_PFX = 2'd1,
    REV_OK  = 2'd2,
    REV_PFX = 2'd3
  } word_class_e;

  function automatic logic class_is_rev(input word_class_e c);
    return (c == REV_OK) || (c == REV_PFX);
  endfunction

  function automatic logic class_is_pfx(input word_class_e c);
    return (c == FWD_PFX) || (c == REV_PFX);
  endfunction

endpackage

// File: rtl/dna_suffix_classify.sv
// Priority classifier of a word's 2-digit suffix into forward/reverse and
// clean/prefix-corrupted classes.
module dna_suffix_classify
  import dna_pkg::*;
#(
  parameter logic [SUFFIX_W-1:0] SUF_FWD = 4'b0100,
  parameter logic [SUFFIX_W-1:0] SUF_REV = 4'b1011
) (
  input  logic [SUFFIX_W-1:0] i_suffix,
  output word_class_e         o_class
);

  logic [DIGIT_W-1:0] w_top_digit;

  assign w_top_digit = i_suffix[SUFFIX_W-1 -: DIGIT_W];

  // A damaged suffix whose leading digit still reads as forward-style is
  // treated as a forward word; the forward test must win over the reverse one.
  always_comb begin
    // NOTE: default assigned first so every path drives o_class; no latch.
    o_class = REV_PFX;
    if (i_suffix == SUF_FWD) begin
      o_class = FWD_OK;
    end else if ((w_top_digit == D1) || (w_top_digit == D4)) begin
      o_class = FWD_PFX;
    end else if (i_suffix == SUF_REV) begin
      o_class = REV_OK;
    end
  end

endmodule

// File: rtl/dna_word_orienter.sv
// Two-stage valid/ready pipeline that classifies DNA words by suffix,
// re-orients reverse words to forward form and keeps saturating class counts.
module dna_word_orienter
  import dna_pkg::*;
#(
  parameter int                  N_DIGITS = 6,
  parameter logic [SUFFIX_W-1:0] SUF_FWD  = 4'b0100,
  parameter logic [SUFFIX_W-1:0] SUF_REV  = 4'b1011,
  parameter int                  REV_MODE = 2,
  parameter int                  CNT_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DIGIT_W*N_DIGITS-1:0] in_word,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DIGIT_W*N_DIGITS-1:0] out_word,
  output logic                        out_reversed,
  output logic                        out_in_prefix,
  input  logic                        cnt_clr,
  output logic [CNT_W-1:0]            cnt_fwd_ok,
  output logic [CNT_W-1:0]            cnt_fwd_pfx,
  output logic [CNT_W-1:0]            cnt_rev_ok,
  output logic [CNT_W-1:0]            cnt_rev_pfx
);

  localparam int WORD_W = DIGIT_W * N_DIGITS;

  logic              r_s1_valid;
  logic [WORD_W-1:0] r_s1_word;
  word_class_e       r_s1_class;

  logic              r_s2_valid;
  logic [WORD_W-1:0] r_s2_word;
  logic              r_s2_rev;
  logic              r_s2_pfx;
  word_class_e       r_s2_class;

  logic [CNT_W-1:0]  r_cnt [N_CLASSES];

  word_class_e       w_in_class;
  logic              w_s1_adv;
  logic              w_s2_adv;
  logic              w_s1_rev;
  logic [WORD_W-1:0] w_reversed;
  logic [WORD_W-1:0] w_xform;
  logic [WORD_W-1:0] w_s2_word;
  logic              w_out_fire;

  dna_suffix_classify #(
    .SUF_FWD (SUF_FWD),
    .SUF_REV (SUF_REV)
  ) u_classify (
    .i_suffix (in_word[WORD_W-1 -: SUFFIX_W]),
    .o_class  (w_in_class)
  );

  // A stage may load whenever it is empty or its contents move on this edge,
  // so backpressure ripples combinationally from out_ready to in_ready.
  assign w_s2_adv   = !r_s2_valid || out_ready;
  assign w_s1_adv   = !r_s1_valid || w_s2_adv;
  assign in_ready   = w_s1_adv;
  assign w_out_fire = r_s2_valid && out_ready;

  always_comb begin
    w_reversed = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      w_reversed[DIGIT_W*(N_DIGITS-1-k) +: DIGIT_W] = r_s1_word[DIGIT_W*k +: DIGIT_W];
    end
  end

  // Per-digit complement (XOR 2'b11) is a plain bitwise inversion of the word.
  if (REV_MODE == REV_MODE_REVERSE) begin : g_mode_reverse
    assign w_xform = w_reversed;
  end else if (REV_MODE == REV_MODE_COMPLEMENT) begin : g_mode_complement
    assign w_xform = ~r_s1_word;
  end else begin : g_mode_revcomp
    assign w_xform = ~w_reversed;
  end

  assign w_s1_rev  = class_is_rev(r_s1_class);
  assign w_s2_word = w_s1_rev ? w_xform : r_s1_word;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_word  <= '0;
      r_s1_class <= FWD_OK;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_word  <= in_word;
        r_s1_class <= w_in_class;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_word  <= '0;
      r_s2_rev   <= 1'b0;
      r_s2_pfx   <= 1'b0;
      r_s2_class <= FWD_OK;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_word  <= w_s2_word;
        r_s2_rev   <= w_s1_rev;
        r_s2_pfx   <= class_is_pfx(r_s1_class);
        r_s2_class <= r_s1_class;
      end
    end
  end

  // Clear takes priority over a same-cycle increment; counters stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CLASSES; i++) begin
        r_cnt[i] <= '0;
      end
    end else if (cnt_clr) begin
      for (int i = 0; i < N_CLASSES; i++) begin
        r_cnt[i] <= '0;
      end
    end else if (w_out_fire && (r_cnt[r_s2_class] != '1)) begin
      r_cnt[r_s2_class] <= r_cnt[r_s2_class] + CNT_W'(1);
    end
  end

  assign out_valid     = r_s2_valid;
  assign out_word      = r_s2_word;
  assign out_reversed  = r_s2_rev;
  assign out_in_prefix = r_s2_pfx;

  assign cnt_fwd_ok  = r_cnt[FWD_OK];
  assign cnt_fwd_pfx = r_cnt[FWD_PFX];
  assign cnt_rev_ok  = r_cnt[REV_OK];
  assign cnt_rev_pfx = r_cnt[REV_PFX];

endmodule

// File: tb/tb_dna_word_orienter.sv
// Directed bench for dna_word_orienter: classification, reverse-complement,
// 2-cycle latency, stall behaviour, saturating counters and async reset.
module tb_dna_word_orienter;

  localparam int N_DIGITS = 6;
  localparam int WORD_W   = 12;
  localparam int CNT_W    = 2;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_word;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_word;
  logic              out_reversed;
  logic              out_in_prefix;
  logic              cnt_clr;
  logic [CNT_W-1:0]  cnt_fwd_ok;
  logic [CNT_W-1:0]  cnt_fwd_pfx;
  logic [CNT_W-1:0]  cnt_rev_ok;
  logic [CNT_W-1:0]  cnt_rev_pfx;

  int n_checks;
  int n_errors;

  dna_word_orienter #(
    .N_DIGITS (N_DIGITS),
    .SUF_FWD  (4'b0100),
    .SUF_REV  (4'b1011),
    .REV_MODE (2),
    .CNT_W    (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_word       (in_word),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_word      (out_word),
    .out_reversed  (out_reversed),
    .out_in_prefix (out_in_prefix),
    .cnt_clr       (cnt_clr),
    .cnt_fwd_ok    (cnt_fwd_ok),
    .cnt_fwd_pfx   (cnt_fwd_pfx),
    .cnt_rev_ok    (cnt_rev_ok),
    .cnt_rev_pfx   (cnt_rev_pfx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_cnts(input string tag, input int fo, input int fp, input int ro, input int rp);
    check({tag, "_fwd_ok"},  cnt_fwd_ok,  fo);
    check({tag, "_fwd_pfx"}, cnt_fwd_pfx, fp);
    check({tag, "_rev_ok"},  cnt_rev_ok,  ro);
    check({tag, "_rev_pfx"}, cnt_rev_pfx, rp);
  endtask

  // One word through an idle pipeline with out_ready high; checks exact latency.
  task automatic send_word(input logic [WORD_W-1:0] w, input logic [WORD_W-1:0] exp_w,
                           input logic exp_rev, input logic exp_pfx, input logic clr_at_out);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_word   = w;
    #1 check("hs_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_word  = ~w;
    check("lat1_valid", out_valid, 0);
    @(negedge clk);
    check("lat2_valid", out_valid, 1);
    check("out_word", out_word, exp_w);
    check("out_reversed", out_reversed, exp_rev);
    check("out_in_prefix", out_in_prefix, exp_pfx);
    cnt_clr = clr_at_out;
    @(negedge clk);
    cnt_clr = 1'b0;
    check("drain_valid", out_valid, 0);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [WORD_W-1:0] s_words [8];
    logic [WORD_W-1:0] s_exp   [8];
    logic [WORD_W-1:0] held;
    logic              stalled_prev;
    logic              saw_not_ready;
    int                in_idx;
    int                out_idx;

    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_word   = '0;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;

    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_word", out_word, 0);
    check("rst_out_reversed", out_reversed, 0);
    check("rst_out_in_prefix", out_in_prefix, 0);
    check("rst_in_ready", in_ready, 1);
    check_cnts("rst", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed classification and transform vectors.
    send_word(12'h432, 12'h432, 1'b0, 1'b0, 1'b0);
    check_cnts("after_fwd_ok", 1, 0, 0, 0);
    send_word(12'hB1B, 12'h1B1, 1'b1, 1'b0, 1'b0);
    check_cnts("after_rev_ok", 1, 0, 1, 0);
    send_word(12'h7A5, 12'h7A5, 1'b0, 1'b1, 1'b0);
    send_word(12'h0C6, 12'h0C6, 1'b0, 1'b1, 1'b0);
    send_word(12'hD2C, 12'hC78, 1'b1, 1'b1, 1'b0);
    send_word(12'h8F0, 12'hF0D, 1'b1, 1'b1, 1'b0);
    check_cnts("after_directed", 1, 2, 1, 2);

    // Back-to-back stream with out_ready low for cycles 3..5.
    s_words = '{12'h432, 12'hB1B, 12'h7A5, 12'h0C6, 12'hD2C, 12'h8F0, 12'h4FF, 12'hBE4};
    s_exp   = '{12'h432, 12'h1B1, 12'h7A5, 12'h0C6, 12'hC78, 12'hF0D, 12'h4FF, 12'hE41};
    in_idx        = 0;
    out_idx       = 0;
    stalled_prev  = 1'b0;
    saw_not_ready = 1'b0;
    held          = '0;
    for (int c = 0; (c < 60) && (out_idx < 8); c++) begin
      @(negedge clk);
      out_ready = !((c >= 3) && (c <= 5));
      in_valid  = (in_idx < 8);
      in_word   = (in_idx < 8) ? s_words[in_idx] : 12'hFFF;
      #1;
      if (stalled_prev) check("stall_hold", out_word, held);
      if ((c >= 3) && (c <= 5) && !in_ready) saw_not_ready = 1'b1;
      if (out_valid && out_ready) begin
        check("stream_order", out_word, s_exp[out_idx]);
        out_idx++;
      end
      stalled_prev = out_valid && !out_ready;
      held         = out_word;
      if (in_valid && in_ready) in_idx++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_count", out_idx, 8);
    check("stream_in_count", in_idx, 8);
    check("in_ready_drop", saw_not_ready, 1);
    repeat (3) begin
      @(negedge clk);
      check("stream_no_extra", out_valid, 0);
    end

    // Saturation with 2-bit counters.
    pulse_clear();
    check_cnts("clr", 0, 0, 0, 0);
    send_word(12'h4AB, 12'h4AB, 1'b0, 1'b0, 1'b0);
    check("sat1", cnt_fwd_ok, 1);
    send_word(12'h412, 12'h412, 1'b0, 1'b0, 1'b0);
    check("sat2", cnt_fwd_ok, 2);
    send_word(12'h4C3, 12'h4C3, 1'b0, 1'b0, 1'b0);
    check("sat3", cnt_fwd_ok, 3);
    send_word(12'h400, 12'h400, 1'b0, 1'b0, 1'b0);
    check("sat4", cnt_fwd_ok, 3);
    send_word(12'h4FF, 12'h4FF, 1'b0, 1'b0, 1'b0);
    check("sat5", cnt_fwd_ok, 3);

    // Clear coinciding with an output handshake must win.
    pulse_clear();
    check("clr_before_race", cnt_fwd_ok, 0);
    send_word(12'h432, 12'h432, 1'b0, 1'b0, 1'b1);
    check("clr_beats_inc", cnt_fwd_ok, 0);

    // Asynchronous reset with both stages holding words.
    send_word(12'h432, 12'h432, 1'b0, 1'b0, 1'b0);
    check("pre_rst_cnt", cnt_fwd_ok, 1);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_word   = 12'h4AA;
    @(negedge clk);
    in_word = 12'hB1B;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("pre_rst_full_valid", out_valid, 1);
    check("pre_rst_in_ready", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_word", out_word, 0);
    check("async_rst_in_ready", in_ready, 1);
    check_cnts("async_rst", 0, 0, 0, 0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_discard", out_valid, 0);
    end
    send_word(12'hB1B, 12'h1B1, 1'b1, 1'b0, 1'b0);
    check_cnts("post_rst", 0, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
